// File: rtl/interrupt_request_controller.sv
// Interrupt request front end: edge-detects request lines, latches them as pending,
// arbitrates by fixed priority and drives a timed interrupt pulse until the handler returns.
module interrupt_request_controller #(
    parameter int NUM_SRC   = 4,
    parameter int PULSE_LEN = 2,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               rti_done,
    output logic               interrupt_signal,
    output logic [2:0]         irq_id,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic [CNT_W-1:0]   lost_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0]         PULSE_END = 4'(PULSE_LEN);
    localparam logic [CNT_W-1:0]   LOST_MAX  = {CNT_W{1'b1}};
    localparam logic [NUM_SRC-1:0] SRC_ZERO  = {NUM_SRC{1'b0}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;
    logic               int_r;
    logic               int_nxt_s;
    logic [2:0]         id_r;
    logic [2:0]         id_nxt_s;
    logic               busy_r;
    logic [NUM_SRC-1:0] prev_r;
    logic [NUM_SRC-1:0] pend_r;
    logic [NUM_SRC-1:0] pend_nxt_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] elig_s;
    logic [NUM_SRC-1:0] clear_s;
    logic [CNT_W-1:0]   lost_r;
    logic               lost_s;
    logic               grant_s;
    logic [2:0]         winner_s;

    // Lowest set index wins; source 0 has the highest priority.
    function automatic logic [2:0] pick_lowest(input logic [NUM_SRC-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign rise_s   = irq_in & ~prev_r;
    assign elig_s   = pend_r & ~irq_mask;
    assign winner_s = pick_lowest(elig_s);
    assign grant_s  = (state_r == ST_IDLE) && (elig_s != SRC_ZERO);

    // Pending update: the grant clears the winner, a new edge sets (set wins).
    always_comb begin
        clear_s = SRC_ZERO;
        for (int i = 0; i < NUM_SRC; i++) begin
            clear_s[i] = grant_s && (winner_s == 3'(i));
        end
        pend_nxt_s = (pend_r & ~clear_s) | rise_s;
        // A re-set on the bit being granted this cycle is not a lost request.
        lost_s     = |(rise_s & pend_r & ~clear_s);
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        int_nxt_s   = int_r;
        id_nxt_s    = id_r;
        case (state_r)
            ST_IDLE: begin
                int_nxt_s = 1'b0;
                if (grant_s) begin
                    state_nxt_s = ST_PULSE;
                    id_nxt_s    = winner_s;
                    int_nxt_s   = 1'b1;
                    cnt_nxt_s   = 4'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                int_nxt_s = 1'b1;
                if (cnt_r == PULSE_END) begin
                    state_nxt_s = ST_SERVICE;
                    int_nxt_s   = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            ST_SERVICE: begin
                int_nxt_s = 1'b0;
                if (rti_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                int_nxt_s   = 1'b0;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            int_r   <= 1'b0;
            id_r    <= 3'd0;
            busy_r  <= 1'b0;
            pend_r  <= SRC_ZERO;
            lost_r  <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            int_r   <= int_nxt_s;
            id_r    <= id_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            pend_r  <= pend_nxt_s;
            if (lost_s && (lost_r != LOST_MAX)) begin
                lost_r <= lost_r + CNT_W'(1'b1);
            end else begin
                lost_r <= lost_r;
            end
        end
    end

    // Edge history keeps tracking during reset so lines held high across
    // reset do not register as fresh edges on release.
    always_ff @(posedge clk) begin
        prev_r <= irq_in;
    end

    assign interrupt_signal = int_r;
    assign irq_id           = id_r;
    assign busy             = busy_r;
    assign pending          = pend_r;
    assign lost_count       = lost_r;

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed bench for interrupt_request_controller: stimulus pushes expected grants
// into a scoreboard queue; a negedge monitor checks each interrupt pulse against it.
module tb_interrupt_request_controller;

    localparam int NUM_SRC   = 4;
    localparam int PULSE_LEN = 2;
    localparam int CNT_W     = 8;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] irq_mask;
    logic               rti_done;
    logic               interrupt_signal;
    logic [2:0]         irq_id;
    logic               busy;
    logic [NUM_SRC-1:0] pending;
    logic [CNT_W-1:0]   lost_count;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_prev;
    logic mon_in;
    int   mon_len;

    interrupt_request_controller #(
        .NUM_SRC  (NUM_SRC),
        .PULSE_LEN(PULSE_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irq_in          (irq_in),
        .irq_mask        (irq_mask),
        .rti_done        (rti_done),
        .interrupt_signal(interrupt_signal),
        .irq_id          (irq_id),
        .busy            (busy),
        .pending         (pending),
        .lost_count      (lost_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_grant(input int id, input int at_cyc);
        exp_t e;
        e.id  = id;
        e.cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic rti_pulse();
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        check("busy_after_rti", busy, 1'b0);
    endtask

    // Called on the cycle a grant becomes visible: wait into SERVICE, then return.
    task automatic finish_grant(input int next_id);
        tick();
        tick();
        check("service_busy", busy, 1'b1);
        check("service_int_low", interrupt_signal, 1'b0);
        if (next_id >= 0) push_grant(next_id, cyc + 2);
        rti_pulse();
    endtask

    // Scoreboard monitor: each rising interrupt_signal pops one expected grant.
    initial begin
        mon_prev = 1'b0;
        mon_in   = 1'b0;
        mon_len  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
                mon_in   = 1'b0;
                mon_len  = 0;
            end else begin
                if (interrupt_signal && !mon_prev) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_grant: got id %0d at cycle %0d, required no grant", irq_id, cyc);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("grant_id", 32'(irq_id), mon_e.id);
                        check("grant_cycle", cyc, mon_e.cyc);
                    end
                    mon_in  = 1'b1;
                    mon_len = 1;
                end else if (interrupt_signal && mon_in) begin
                    mon_len++;
                end else if (!interrupt_signal && mon_prev && mon_in) begin
                    check("pulse_len", mon_len, PULSE_LEN);
                    mon_in = 1'b0;
                end
                mon_prev = interrupt_signal;
            end
        end
    end

    initial begin
        int c;
        rst      = 1'b1;
        irq_in   = 4'b1111;
        irq_mask = 4'b0000;
        rti_done = 1'b0;

        // 1: reset with all lines high; no edge seen on release
        tick(); tick(); tick();
        check("rst_pending", pending, 4'b0000);
        check("rst_int", interrupt_signal, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_id", irq_id, 3'd0);
        check("rst_lost", lost_count, 8'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("release_pending", pending, 4'b0000);
        check("release_busy", busy, 1'b0);
        irq_in = 4'b0000;
        tick(); tick();

        // 2: single source 2
        c = cyc;
        irq_in = 4'b0100;
        push_grant(2, c + 2);
        tick();
        check("t2_pending_set", pending, 4'b0100);
        check("t2_not_yet", interrupt_signal, 1'b0);
        tick();
        check("t2_int_high", interrupt_signal, 1'b1);
        check("t2_busy", busy, 1'b1);
        check("t2_pending_clr", pending, 4'b0000);
        finish_grant(-1);
        irq_in = 4'b0000;
        tick();

        // 3: sources 1 and 3 together; 1 first, 3 two cycles after RTI
        c = cyc;
        irq_in = 4'b1010;
        push_grant(1, c + 2);
        tick(); tick();
        check("t3_id1", irq_id, 3'd1);
        check("t3_pending", pending, 4'b1000);
        finish_grant(3);
        tick();
        check("t3_id3", irq_id, 3'd3);
        finish_grant(-1);
        check("t3_lost", lost_count, 8'd0);
        irq_in = 4'b0000;
        tick();

        // 4: masked source 0 stays pending, source 3 granted, unmask in SERVICE
        irq_mask = 4'b0001;
        irq_in   = 4'b0001;
        tick();
        check("t4_masked_pending", pending, 4'b0001);
        tick(); tick();
        check("t4_masked_idle", busy, 1'b0);
        c = cyc;
        irq_in = 4'b1001;
        push_grant(3, c + 2);
        tick(); tick();
        check("t4_id3", irq_id, 3'd3);
        check("t4_src0_kept", pending, 4'b0001);
        tick(); tick();
        irq_mask = 4'b0000;
        tick();
        check("t4_mask_no_effect", busy, 1'b1);
        check("t4_id_hold", irq_id, 3'd3);
        push_grant(0, cyc + 2);
        rti_pulse();
        tick();
        check("t4_id0", irq_id, 3'd0);
        check("t4_pending_clr", pending, 4'b0000);
        finish_grant(-1);
        irq_in = 4'b0000;
        tick();

        // multi-source re-rise counts one lost request
        irq_mask = 4'b0101;
        irq_in   = 4'b0101;
        tick();
        check("mr_pending", pending, 4'b0101);
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0101;
        tick();
        check("mr_lost_once", lost_count, 8'd1);
        irq_in = 4'b0000;
        tick();
        irq_mask = 4'b0000;
        push_grant(0, cyc + 1);
        tick();
        check("mr_id0", irq_id, 3'd0);
        finish_grant(2);
        tick();
        check("mr_id2", irq_id, 3'd2);
        finish_grant(-1);

        // same-cycle clear and set on the winner: set wins, not lost
        irq_mask = 4'b0100;
        irq_in   = 4'b0100;
        tick();
        irq_in = 4'b0000;
        tick();
        irq_in   = 4'b0100;
        irq_mask = 4'b0000;
        push_grant(2, cyc + 1);
        tick();
        check("sc_set_wins", pending, 4'b0100);
        check("sc_not_lost", lost_count, 8'd1);
        finish_grant(2);
        tick();
        check("sc_regrant_clr", pending, 4'b0000);
        finish_grant(-1);
        irq_in = 4'b0000;
        tick();

        // 5: 300 edges on masked source 1 saturate the lost counter
        irq_mask = 4'b0010;
        for (int i = 0; i < 300; i++) begin
            irq_in[1] = 1'b1;
            tick();
            irq_in[1] = 1'b0;
            tick();
            if (i == 10) check("t5_lost_mid", lost_count, 8'd11);
        end
        check("t5_lost_sat", lost_count, 8'hFF);
        check("t5_pending", pending, 4'b0010);
        check("t5_idle", busy, 1'b0);
        irq_mask = 4'b0000;
        push_grant(1, cyc + 1);
        tick();
        check("t5_int", interrupt_signal, 1'b1);
        finish_grant(-1);
        check("t5_lost_hold", lost_count, 8'hFF);

        // 6: reset during PULSE, then RTI in IDLE has no effect
        irq_mask = 4'b1000;
        irq_in   = 4'b1001;
        push_grant(0, cyc + 2);
        tick(); tick();
        check("t6_int", interrupt_signal, 1'b1);
        check("t6_pending", pending, 4'b1000);
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_int", interrupt_signal, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_pending", pending, 4'b0000);
        check("t6_rst_lost", lost_count, 8'd0);
        check("t6_rst_id", irq_id, 3'd0);
        rst = 1'b0;
        tick();
        rti_pulse();
        tick();
        check("t6_idle_pending", pending, 4'b0000);
        check("t6_idle_int", interrupt_signal, 1'b0);
        check("t6_idle_busy", busy, 1'b0);
        irq_in = 4'b0000;
        tick(); tick();
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
